// File: rtl/msp430_boot_seq.sv
// Purpose : reset/boot sequencer; stretches core reset, fetches the reset vector, loads PC/SP/SR, releases the core.
// Latency : RST_STRETCH cycles in STRETCH, then at least one FETCH cycle, then one LOAD cycle; core_rst falls one cycle after pc_load.
// Backpres: mem_req is held until mem_ready; after TIMEOUT cycles it drops for one cycle and retries, and faults after MAX_RETRY retries.
//
// Ports:
//   clk, rst (async, active-low)    - clock and system reset
//   soft_rst                        - synchronous re-boot request, ignored while in RESET
//   mem_req/mem_addr/mem_ready/mem_rdata - single-word read of the reset vector
//   core_rst, pc_load, pc_val, sp_val, sr_val - pipeline reset and initial register load
//   boot_done, fault                - core running / boot failed (core held in reset)
//
// Optional build macro BOOT_VEC_CHECK_EN: when defined, an erased (FFFF), zero or odd
// vector sends the sequencer to FAULT instead of LOAD. When undefined, any vector is
// accepted and bit0 is cleared.
module msp430_boot_seq #(
    parameter int                DATA_W       = 16,
    parameter int                ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] RST_VEC_ADDR = 16'hFFFE,
    parameter logic [DATA_W-1:0] SP_INIT      = 16'h0400,
    parameter logic [DATA_W-1:0] SR_INIT      = 16'h0000,
    parameter int                RST_STRETCH  = 4,
    parameter int                TIMEOUT      = 15,
    parameter int                MAX_RETRY    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              soft_rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              core_rst,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_val,
    output logic [DATA_W-1:0] sp_val,
    output logic [DATA_W-1:0] sr_val,
    output logic              boot_done,
    output logic              fault
);

    localparam logic [2:0] S_RESET   = 3'd0;
    localparam logic [2:0] S_STRETCH = 3'd1;
    localparam logic [2:0] S_FETCH   = 3'd2;
    localparam logic [2:0] S_LOAD    = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd4;
    localparam logic [2:0] S_FAULT   = 3'd5;

    localparam int SW = $clog2(RST_STRETCH + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    // +2 keeps the retry counter at least one bit wide when MAX_RETRY is 0
    localparam int RW = $clog2(MAX_RETRY + 2);

    localparam logic [SW-1:0]     STRETCH_LAST = SW'(RST_STRETCH - 1);
    localparam logic [WW-1:0]     WAIT_LAST    = WW'(TIMEOUT - 1);
    localparam logic [RW-1:0]     RETRY_LAST   = RW'(MAX_RETRY);
    localparam logic [DATA_W-1:0] EVEN_MASK    = ~DATA_W'(1);

    logic [2:0]    state;
    logic [SW-1:0] stretch_cnt;
    logic [WW-1:0] wait_cnt;
    logic [RW-1:0] retry_cnt;
    logic          vec_bad;

`ifdef BOOT_VEC_CHECK_EN
    assign vec_bad = (mem_rdata == '1) || (mem_rdata == '0) || mem_rdata[0];
`else
    assign vec_bad = 1'b0;
`endif

    // All outputs are registered and updated together with the state so
    // that every output reflects the state it belongs to in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_RESET;
            stretch_cnt <= '0;
            wait_cnt    <= '0;
            retry_cnt   <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            core_rst    <= 1'b1;
            pc_load     <= 1'b0;
            pc_val      <= '0;
            sp_val      <= '0;
            sr_val      <= '0;
            boot_done   <= 1'b0;
            fault       <= 1'b0;
        end else begin
            // pc_load is a single-cycle strobe
            pc_load <= 1'b0;

            // soft_rst outranks everything, including a handshake in the same cycle
            if (soft_rst && (state != S_RESET)) begin
                state       <= S_STRETCH;
                stretch_cnt <= STRETCH_LAST;
                wait_cnt    <= '0;
                retry_cnt   <= '0;
                mem_req     <= 1'b0;
                core_rst    <= 1'b1;
                boot_done   <= 1'b0;
                fault       <= 1'b0;
            end else begin
                case (state)
                    S_RESET: begin
                        state       <= S_STRETCH;
                        stretch_cnt <= STRETCH_LAST;
                    end

                    S_STRETCH: begin
                        if (stretch_cnt == '0) begin
                            state     <= S_FETCH;
                            mem_req   <= 1'b1;
                            mem_addr  <= RST_VEC_ADDR;
                            wait_cnt  <= '0;
                            retry_cnt <= '0;
                        end else begin
                            stretch_cnt <= stretch_cnt - 1'b1;
                        end
                    end

                    S_FETCH: begin
                        if (!mem_req) begin
                            // end of the one-cycle retry gap; mem_ready is ignored here
                            mem_req <= 1'b1;
                        end else if (mem_ready) begin
                            mem_req  <= 1'b0;
                            wait_cnt <= '0;
                            if (vec_bad) begin
                                state <= S_FAULT;
                                fault <= 1'b1;
                            end else begin
                                state   <= S_LOAD;
                                pc_load <= 1'b1;
                                pc_val  <= mem_rdata & EVEN_MASK;
                                sp_val  <= SP_INIT & EVEN_MASK;
                                sr_val  <= SR_INIT;
                            end
                        end else if (wait_cnt == WAIT_LAST) begin
                            // TIMEOUT cycles without ready: drop the request once, then retry or give up
                            wait_cnt <= '0;
                            mem_req  <= 1'b0;
                            if (retry_cnt == RETRY_LAST) begin
                                state <= S_FAULT;
                                fault <= 1'b1;
                            end else begin
                                retry_cnt <= retry_cnt + 1'b1;
                            end
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end

                    S_LOAD: begin
                        state     <= S_RUN;
                        core_rst  <= 1'b0;
                        boot_done <= 1'b1;
                    end

                    S_RUN: begin
                        // core running; register values hold
                    end

                    S_FAULT: begin
                        // terminal until rst or soft_rst
                    end

                    default: begin
                        state <= S_RESET;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_msp430_boot_seq.sv
// Purpose : scoreboard bench for msp430_boot_seq; boots are issued with random memory latencies and data.
// Latency : expected events (request, load, run, fault) are predicted as absolute cycle numbers.
// Backpres: a memory responder answers each request window after a chosen number of wait cycles, or never.
module tb_msp430_boot_seq;

    localparam int RST_STRETCH = 4;
    localparam int TIMEOUT     = 15;
    localparam int MAX_RETRY   = 2;
    localparam int NEVER       = 99;

    localparam int K_REQ   = 0;
    localparam int K_LOAD  = 1;
    localparam int K_FAULT = 2;
    localparam int K_RUN   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        soft_rst = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic        core_rst;
    logic        pc_load;
    logic [15:0] pc_val;
    logic [15:0] sp_val;
    logic [15:0] sr_val;
    logic        boot_done;
    logic        fault;

    msp430_boot_seq #(
        .DATA_W      (16),
        .ADDR_W      (16),
        .RST_VEC_ADDR(16'hFFFE),
        .SP_INIT     (16'h0400),
        .SR_INIT     (16'h0000),
        .RST_STRETCH (RST_STRETCH),
        .TIMEOUT     (TIMEOUT),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .soft_rst (soft_rst),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .core_rst (core_rst),
        .pc_load  (pc_load),
        .pc_val   (pc_val),
        .sp_val   (sp_val),
        .sr_val   (sr_val),
        .boot_done(boot_done),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        int          cyc;
        logic [15:0] pc;
    } ev_t;

    ev_t sb[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc   = 0;

    // driver-owned stimulus context for the responder
    int  cur_lat[4] = '{0, 0, 0, NEVER};
    int  boot_id = 0;

    always @(posedge clk) cyc++;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", nm, cyc, act, req);
        end
    endfunction

    // ---------------- reference model ----------------
    function automatic void exp_ev(int kind, int c, logic [15:0] pc, int cut);
        ev_t e;
        if (c < cut) begin
            e.kind = kind;
            e.cyc  = c;
            e.pc   = pc;
            sb.push_back(e);
        end
    endfunction

    // e: edge that leaves RESET (or samples soft_rst). Events at or after 'cut'
    // are pre-empted by the next boot. Returns the cycle of the last event.
    function automatic int model_boot(int e, int l0, int l1, int l2, logic [15:0] d, int cut);
        int lat[3];
        int f;
        bit bad;
        lat[0] = l0; lat[1] = l1; lat[2] = l2;
        f = e + RST_STRETCH;
`ifdef BOOT_VEC_CHECK_EN
        bad = (d == 16'hFFFF) || (d == 16'h0000) || (d[0] == 1'b1);
`else
        bad = 1'b0;
`endif
        for (int a = 0; a <= MAX_RETRY; a++) begin
            exp_ev(K_REQ, f, 16'h0000, cut);
            if (lat[a] < TIMEOUT) begin
                if (bad) begin
                    exp_ev(K_FAULT, f + lat[a] + 1, 16'h0000, cut);
                    return f + lat[a] + 1;
                end
                exp_ev(K_LOAD, f + lat[a] + 1, d & 16'hFFFE, cut);
                exp_ev(K_RUN,  f + lat[a] + 2, d & 16'hFFFE, cut);
                return f + lat[a] + 2;
            end
            if (a == MAX_RETRY) begin
                exp_ev(K_FAULT, f + TIMEOUT, 16'h0000, cut);
                return f + TIMEOUT;
            end
            f = f + TIMEOUT + 1;
        end
        return f;
    endfunction

    // ---------------- memory responder ----------------
    int att = 0;
    int age = 0;
    int seen_id = 0;
    bit r_prev = 1'b0;

    always @(posedge clk) begin
        #2;
        if (boot_id != seen_id) begin
            seen_id = boot_id;
            att     = 0;
            age     = 0;
            r_prev  = 1'b0;
        end
        if (mem_req) begin
            mem_ready = (age == cur_lat[(att > 3) ? 3 : att]);
            age++;
        end else begin
            if (r_prev) att++;
            age       = 0;
            mem_ready = 1'($urandom_range(0, 1));   // noise while idle must be ignored
        end
        r_prev = mem_req;
    end

    // ---------------- monitor ----------------
    bit p_req  = 1'b0;
    bit p_flt  = 1'b0;
    bit p_done = 1'b0;

    function automatic void got(int kind);
        ev_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_event at cycle %0d: got kind %0d, required none", cyc, kind);
        end else begin
            e = sb.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            chk("event_cycle", 32'(cyc), 32'(e.cyc));
            if (kind == K_LOAD || kind == K_RUN)
                chk("pc_val", 32'(pc_val), 32'(e.pc));
        end
    endfunction

    always @(posedge clk) begin
        #1;
        chk("core_rst_vs_boot_done", 32'(core_rst), 32'(!boot_done));
        if (mem_req && !p_req) begin
            got(K_REQ);
            chk("mem_addr", 32'(mem_addr), 32'h0000FFFE);
        end
        if (pc_load) begin
            got(K_LOAD);
            chk("sp_val", 32'(sp_val), 32'h00000400);
            chk("sr_val", 32'(sr_val), 32'h00000000);
        end
        if (fault && !p_flt) begin
            got(K_FAULT);
            chk("fault_core_rst", 32'(core_rst), 32'd1);
            chk("fault_mem_req", 32'(mem_req), 32'd0);
        end
        if (boot_done && !p_done) begin
            got(K_RUN);
            chk("run_core_rst", 32'(core_rst), 32'd0);
        end
        p_req  = mem_req;
        p_flt  = fault;
        p_done = boot_done;
    end

    // ---------------- driver ----------------
    // Called at a negedge. run_len: cycles after the start edge before the next
    // boot may pre-empt this one (large value = let it finish).
    task automatic do_boot(input bit use_soft, input int l0, input int l1, input int l2,
                           input logic [15:0] d, input int run_len);
        int e;
        int cut;
        int last;
        int target;
        chk("leftover_events", 32'(sb.size()), 32'd0);
        boot_id++;
        cur_lat   = '{l0, l1, l2, NEVER};
        mem_rdata = d;
        if (use_soft) begin
            soft_rst = 1'b1;
            e = cyc + 1;
            @(negedge clk);
            soft_rst = 1'b0;
            chk("soft_core_rst", 32'(core_rst), 32'd1);
            chk("soft_boot_done", 32'(boot_done), 32'd0);
            chk("soft_fault", 32'(fault), 32'd0);
            chk("soft_mem_req", 32'(mem_req), 32'd0);
        end else begin
            rst = 1'b0;
            #1;
            chk("rst_mem_req", 32'(mem_req), 32'd0);
            chk("rst_mem_addr", 32'(mem_addr), 32'd0);
            chk("rst_core_rst", 32'(core_rst), 32'd1);
            chk("rst_pc_load", 32'(pc_load), 32'd0);
            chk("rst_pc_val", 32'(pc_val), 32'd0);
            chk("rst_sp_val", 32'(sp_val), 32'd0);
            chk("rst_sr_val", 32'(sr_val), 32'd0);
            chk("rst_boot_done", 32'(boot_done), 32'd0);
            chk("rst_fault", 32'(fault), 32'd0);
            repeat (2) @(negedge clk);
            rst = 1'b1;
            e = cyc + 1;
        end
        cut  = e + run_len;
        last = model_boot(e, l0, l1, l2, d, cut);
        target = (cut <= last + 1) ? cut - 1 : last + 2;
        while (cyc < target) @(negedge clk);
    endtask

    function automatic logic [15:0] pick_data();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 5))
            0:       return 16'hFFFF;
            1:       return 16'h0000;
            2:       return v | 16'h0001;
            default: return v;
        endcase
    endfunction

    initial begin
        int l[3];
        int rl;
        #2;
        // zero-wait boot
        do_boot(1'b0, 0, 0, 0, 16'hC000, 1000);
        // soft reset while running, new vector
        do_boot(1'b1, 0, 0, 0, 16'hC100, 1000);
        // five wait states
        do_boot(1'b0, 5, 0, 0, 16'h1234, 1000);
        // ready on the last cycle before timeout
        do_boot(1'b0, TIMEOUT - 1, 0, 0, 16'h8A42, 1000);
        // no response at all: three windows then fault
        do_boot(1'b0, NEVER, NEVER, NEVER, 16'h5678, 1000);
        // soft reset out of FAULT with a responsive memory
        do_boot(1'b1, 0, 0, 0, 16'hC000, 1000);
        // two timeouts then success on the final retry
        do_boot(1'b1, NEVER, NEVER, 3, 16'hE002, 1000);
        // async reset while the request is outstanding
        do_boot(1'b0, NEVER, NEVER, NEVER, 16'h4444, RST_STRETCH + 3);
        // erased-flash vector
        do_boot(1'b0, 0, 0, 0, 16'hFFFF, 1000);
        // soft reset on the same edge as a completing handshake
        do_boot(1'b1, 2, 0, 0, 16'h2222, RST_STRETCH + 3);
        do_boot(1'b1, 0, 0, 0, 16'h3330, 1000);

        for (int i = 0; i < 30; i++) begin
            for (int a = 0; a < 3; a++) begin
                case ($urandom_range(0, 3))
                    0:       l[a] = NEVER;
                    1:       l[a] = TIMEOUT - 1;
                    default: l[a] = int'($urandom_range(0, TIMEOUT - 1));
                endcase
            end
            rl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 1000;
            do_boot(1'($urandom_range(0, 1)), l[0], l[1], l[2], pick_data(), rl);
        end
        do_boot(1'b0, 1, 0, 0, 16'hABC0, 1000);

        repeat (5) @(negedge clk);
        chk("final_leftover_events", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
